// File: rtl/instruction_sequencer.sv
// Fetch/decode/memory/execute sequencer with a return-address stack; 3 cycles per plain instruction, 4+W for memory ones.
// The memory phase holds address/data/we and waits for mem_ack; HALT and ERROR freeze the core until reset.
module instruction_sequencer #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int INST_DATA_WIDTH = 8,
  parameter int MEM_ADDR_WIDTH  = 8,
  parameter int MEM_DATA_WIDTH  = 8,
  parameter int STACK_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             arst,
  output logic [INST_ADDR_WIDTH-1:0]       inst_addr,
  input  logic [INST_DATA_WIDTH-1:0]       inst_data,
  output logic [MEM_ADDR_WIDTH-1:0]        mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]        mem_data_o,
  input  logic [MEM_DATA_WIDTH-1:0]        mem_data_i,
  output logic                             mem_req,
  output logic                             mem_we,
  input  logic                             mem_ack,
  output logic                             exec,
  input  logic [3:0]                       flags,
  input  logic [MEM_DATA_WIDTH-1:0]        ar,
  output logic [INST_DATA_WIDTH-1:0]       ir,
  output logic [INST_DATA_WIDTH-1:0]       ibr,
  output logic [MEM_DATA_WIDTH-1:0]        mbr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             halted,
  output logic                             error
);

  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = $clog2(STACK_DEPTH);
  localparam int W_I  = (INST_ADDR_WIDTH > INST_DATA_WIDTH) ? INST_ADDR_WIDTH : INST_DATA_WIDTH;
  localparam int W_M  = (MEM_ADDR_WIDTH > MEM_DATA_WIDTH) ? MEM_ADDR_WIDTH : MEM_DATA_WIDTH;
  localparam int XW   = (W_I > W_M) ? W_I : W_M;

  localparam logic [7:0] OP_LOAD_X  = 8'h01;
  localparam logic [7:0] OP_STORE_X = 8'h02;
  localparam logic [7:0] OP_STORE_I = 8'h03;
  localparam logic [7:0] OP_JMP     = 8'h20;
  localparam logic [7:0] OP_JZ      = 8'h21;
  localparam logic [7:0] OP_JC      = 8'h22;
  localparam logic [7:0] OP_JN      = 8'h23;
  localparam logic [7:0] OP_JV      = 8'h24;
  localparam logic [7:0] OP_CALL    = 8'hF0;
  localparam logic [7:0] OP_RET     = 8'hF1;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OV    = 3;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_MEM     = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_DATA_WIDTH-1:0] ir_q, ir_d;
  logic [INST_DATA_WIDTH-1:0] ibr_q, ibr_d;
  logic [MEM_DATA_WIDTH-1:0]  mbr_q, mbr_d;
  logic [MEM_ADDR_WIDTH-1:0]  mar_q, mar_d;
  logic [MEM_DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic                       we_q, we_d;
  logic [SPW-1:0]             sp_q, sp_d;
  logic [INST_ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [7:0]                 op;
  logic                       is_mem_op;
  logic                       flag_hit;
  logic                       fault;
  logic [XW-1:0]              imm_x, ibr_x, ar_x;
  logic [INST_ADDR_WIDTH-1:0] pc_inc, jump_tgt;
  logic [SPW-1:0]             sp_dec;
  logic [IDXW-1:0]            push_idx, pop_idx;

  assign op        = 8'(ir_q);
  assign is_mem_op = (op == OP_LOAD_X) || (op == OP_STORE_X) || (op == OP_STORE_I) ||
                     (op[7:2] == 6'b010000) || (op[7:2] == 6'b100000);
  // Immediates are zero-extended or truncated into whichever width they feed.
  assign imm_x     = XW'(inst_data);
  assign ibr_x     = XW'(ibr_q);
  assign ar_x      = XW'(ar);
  assign pc_inc    = pc_q + INST_ADDR_WIDTH'(1);
  assign jump_tgt  = pc_q + ibr_x[INST_ADDR_WIDTH-1:0];
  assign sp_dec    = sp_q - SPW'(1);
  assign push_idx  = sp_q[IDXW-1:0];
  assign pop_idx   = sp_dec[IDXW-1:0];

  always_comb begin
    flag_hit = 1'b0;
    case (op)
      OP_JZ:   flag_hit = flags[FLAG_ZERO];
      OP_JC:   flag_hit = flags[FLAG_CARRY];
      OP_JN:   flag_hit = flags[FLAG_NEG];
      OP_JV:   flag_hit = flags[FLAG_OV];
      default: flag_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ibr_d   = ibr_q;
    mbr_d   = mbr_q;
    mar_d   = mar_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    fault   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = inst_data;
        pc_d    = pc_inc;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ibr_d = inst_data;
        pc_d  = pc_inc;
        if (is_mem_op) begin
          // The immediate is still on inst_data here, so address/data are set up from it directly.
          state_d = ST_MEM;
          we_d    = (op == OP_STORE_X) || (op == OP_STORE_I);
          mar_d   = (op == OP_STORE_I) ? ar_x[MEM_ADDR_WIDTH-1:0] : imm_x[MEM_ADDR_WIDTH-1:0];
          if (op == OP_STORE_X) wdat_d = ar;
          if (op == OP_STORE_I) wdat_d = imm_x[MEM_DATA_WIDTH-1:0];
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (!we_q) mbr_d = mem_data_i;
          we_d    = 1'b0;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (op)
          OP_JMP: pc_d = jump_tgt;
          OP_JZ, OP_JC, OP_JN, OP_JV: if (flag_hit) pc_d = jump_tgt;
          OP_CALL: begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
              fault   = 1'b1;
              state_d = ST_ERROR;
            end else begin
              stack_d[push_idx] = pc_q;
              pc_d = jump_tgt;
              sp_d = sp_q + SPW'(1);
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              fault   = 1'b1;
              state_d = ST_ERROR;
            end else begin
              pc_d = stack_q[pop_idx];
              sp_d = sp_dec;
            end
          end
          default: ;
        endcase
      end
      ST_HALT, ST_ERROR: ;
      default: state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ibr_q   <= '0;
      mbr_q   <= '0;
      mar_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ibr_q   <= ibr_d;
      mbr_q   <= mbr_d;
      mar_q   <= mar_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      sp_q    <= sp_d;
    end
  end

  // Stack storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!arst) stack_q <= stack_d;
  end

  assign inst_addr  = pc_q;
  assign mem_addr   = mar_q;
  assign mem_data_o = wdat_q;
  assign mem_we     = we_q;
  assign mem_req    = (state_q == ST_MEM);
  assign exec       = (state_q == ST_EXECUTE) && !fault;
  assign ir         = ir_q;
  assign ibr        = ibr_q;
  assign mbr        = mbr_q;
  assign sp         = sp_q;
  assign halted     = (state_q == ST_HALT);
  assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: program image, memory responder with programmable ack delay,
// and a queue of expected memory accesses / execute strobes consumed as the core produces them.
module tb_instruction_sequencer;

  logic       clk;
  logic       arst;
  logic [7:0] inst_addr, inst_data;
  logic [7:0] mem_addr, mem_data_o, mem_data_i;
  logic       mem_req, mem_we, mem_ack, exec;
  logic [3:0] flags;
  logic [7:0] ar, ir, ibr, mbr;
  logic [2:0] sp;
  logic       halted, error;

  instruction_sequencer dut (
    .clk(clk), .arst(arst), .inst_addr(inst_addr), .inst_data(inst_data),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .exec(exec),
    .flags(flags), .ar(ar), .ir(ir), .ibr(ibr), .mbr(mbr), .sp(sp),
    .halted(halted), .error(error)
  );

  typedef struct {
    bit is_mem;
    int a;
    int d;
    bit we;
    int waits;
    int op;
    int npc;
    int nsp;
    int cyc;
    bit mchk;
    int xmbr;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] imem [256];
  int         n_checks = 0;
  int         n_errors = 0;
  int         ack_delay = 0;
  bit         idle_ack = 0;

  assign inst_data = imem[inst_addr];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic exp_mem(input int a, input int d, input bit we, input int waits);
    ev_t e;
    e = '{default: 0};
    e.is_mem = 1; e.a = a; e.d = d; e.we = we; e.waits = waits;
    sb.push_back(e);
  endtask

  task automatic exp_exec(input int op, input int npc, input int nsp, input int cyc,
                          input bit mchk = 0, input int xmbr = 0);
    ev_t e;
    e = '{default: 0};
    e.op = op; e.npc = npc; e.nsp = nsp; e.cyc = cyc; e.mchk = mchk; e.xmbr = xmbr;
    sb.push_back(e);
  endtask

  // Memory responder: acks after ack_delay wait cycles; read data is only meaningful on the ack cycle.
  initial begin
    int waited;
    waited = 0;
    mem_ack = 0;
    mem_data_i = 8'hEE;
    forever begin
      @(posedge clk); #1;
      if (arst) begin
        mem_ack = 1;
        waited = 0;
      end else if (mem_req) begin
        if (waited >= ack_delay) mem_ack = 1;
        else begin
          mem_ack = 0;
          waited++;
        end
      end else begin
        mem_ack = idle_ack;
        waited = 0;
      end
      mem_data_i = (mem_ack && mem_req && !arst) ? (mem_addr ^ 8'h3C) : 8'hEE;
    end
  end

  // Monitor: consumes the scoreboard on each completed access and each exec strobe.
  initial begin
    bit         fetch_next, pend;
    int         cyc, req_cyc;
    logic [7:0] a0, d0;
    logic       we0;
    ev_t        e, pend_e;
    fetch_next = 1; pend = 0; cyc = 0; req_cyc = 0;
    a0 = 0; d0 = 0; we0 = 0;
    pend_e = '{default: 0};
    forever begin
      @(negedge clk);
      if (arst) begin
        fetch_next = 1; pend = 0; req_cyc = 0;
      end else begin
        if (pend) begin
          check("next_pc", 32'(inst_addr), pend_e.npc);
          check("sp_after", 32'(sp), pend_e.nsp);
          pend = 0;
        end
        if (fetch_next) begin
          cyc = 1;
          fetch_next = 0;
        end else cyc++;
        if (mem_req) begin
          if (req_cyc == 0) begin
            a0 = mem_addr; d0 = mem_data_o; we0 = mem_we;
          end else begin
            check("addr_stable", 32'(mem_addr), 32'(a0));
            check("data_stable", 32'(mem_data_o), 32'(d0));
            check("we_stable", 32'(mem_we), 32'(we0));
          end
          req_cyc++;
          if (mem_ack) begin
            if (sb.size() == 0) check("unexpected_mem", 32'(sb.size()), 1);
            else begin
              e = sb.pop_front();
              check("ev_kind_mem", 1, 32'(e.is_mem));
              check("mem_addr", 32'(mem_addr), e.a);
              check("mem_we", 32'(mem_we), 32'(e.we));
              if (e.we) check("mem_data_o", 32'(mem_data_o), e.d);
              check("req_cycles", req_cyc, e.waits + 1);
            end
            req_cyc = 0;
          end
        end
        if (exec) begin
          if (sb.size() == 0) check("unexpected_exec", 32'(sb.size()), 1);
          else begin
            e = sb.pop_front();
            check("ev_kind_exec", 0, 32'(e.is_mem));
            check("exec_op", 32'(ir), e.op);
            check("instr_cycles", cyc, e.cyc);
            if (e.mchk) check("mbr", 32'(mbr), e.xmbr);
            pend_e = e;
            pend = 1;
          end
          fetch_next = 1;
        end
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'hFF;
  endtask

  task automatic do_reset();
    arst = 1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":inst_addr"}, 32'(inst_addr), 0);
    check({tag, ":outs"}, 32'({mem_addr, mem_data_o, ir, ibr, mbr}), 0);
    check({tag, ":sp"}, 32'(sp), 0);
    check({tag, ":ctl"}, 32'({mem_req, mem_we, exec, halted, error}), 0);
  endtask

  task automatic run_to_end(input string tag, input bit exp_h, input bit exp_e,
                            input int exp_pc, input int exp_sp);
    for (int i = 0; i < 300 && !(halted || error); i++) begin
      @(posedge clk); #1;
    end
    check({tag, ":stopped"}, 32'(halted | error), 1);
    check({tag, ":halted"}, 32'(halted), 32'(exp_h));
    check({tag, ":error"}, 32'(error), 32'(exp_e));
    check({tag, ":pc"}, 32'(inst_addr), exp_pc);
    check({tag, ":sp"}, 32'(sp), exp_sp);
    check({tag, ":sb_left"}, 32'(sb.size()), 0);
    repeat (4) begin @(posedge clk); #1; end
    check({tag, ":pc_frozen"}, 32'(inst_addr), exp_pc);
    check({tag, ":quiet"}, 32'({mem_req, exec}), 0);
  endtask

  initial begin
    arst = 1; flags = 0; ar = 0;

    // LOAD_X 0x10 with two wait cycles, then HALT
    clear_imem();
    imem[0] = 8'h01; imem[1] = 8'h10; imem[2] = 8'hFF;
    ack_delay = 2;
    do_reset();
    check_reset("rst_a");
    exp_mem('h10, 0, 0, 2);
    exp_exec('h01, 'h02, 0, 6, 1, 'h2C);
    arst = 0;
    run_to_end("load", 1, 0, 'h04, 0);

    // STORE_I, STORE_X and an ALU read, immediate acks
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h5A; imem[2] = 8'h02; imem[3] = 8'h77;
    imem[4] = 8'h40; imem[5] = 8'h33;
    ack_delay = 0; ar = 8'h20;
    do_reset();
    exp_mem('h20, 'h5A, 1, 0); exp_exec('h03, 'h02, 0, 4);
    exp_mem('h77, 'h20, 1, 0); exp_exec('h02, 'h04, 0, 4);
    exp_mem('h33, 0, 0, 0);    exp_exec('h40, 'h06, 0, 4, 1, 'h0F);
    arst = 0;
    run_to_end("store", 1, 0, 'h08, 0);

    // JMP to 0xFC, JZ +4 taken (wraps to 0x02), JC not taken; acks on an idle bus are ignored
    clear_imem();
    imem[0] = 8'h20; imem[1] = 8'hFA; imem[8'hFC] = 8'h21; imem[8'hFD] = 8'h04;
    imem[2] = 8'h22; imem[3] = 8'h10;
    flags = 4'b0001; idle_ack = 1;
    do_reset();
    exp_exec('h20, 'hFC, 0, 3); exp_exec('h21, 'h02, 0, 3); exp_exec('h22, 'h04, 0, 3);
    arst = 0;
    run_to_end("jz_taken", 1, 0, 'h06, 0);

    // Same JZ with ZERO clear (other flags set): falls through to 0xFE, HALT wraps PC to 0x00
    flags = 4'b1110;
    do_reset();
    exp_exec('h20, 'hFC, 0, 3); exp_exec('h21, 'hFE, 0, 3);
    arst = 0;
    run_to_end("jz_not", 1, 0, 'h00, 0);
    idle_ack = 0; flags = 0;

    // CALL, CALL, RET, RET, then RET on an empty stack
    clear_imem();
    imem[0] = 8'hF0;  imem[1] = 8'h08;  imem[8'h0A] = 8'hF0; imem[8'h0B] = 8'h10;
    imem[8'h1C] = 8'hF1; imem[8'h1D] = 8'h00; imem[8'h0C] = 8'hF1; imem[8'h0D] = 8'h00;
    imem[2] = 8'hF1; imem[3] = 8'h00;
    do_reset();
    exp_exec('hF0, 'h0A, 1, 3); exp_exec('hF0, 'h1C, 2, 3);
    exp_exec('hF1, 'h0C, 1, 3); exp_exec('hF1, 'h02, 0, 3);
    arst = 0;
    run_to_end("call_ret", 0, 1, 'h04, 0);

    // Five nested CALLs overflow a four-entry stack
    clear_imem();
    for (int i = 0; i < 5; i++) begin
      imem[2*i] = 8'hF0;
      imem[2*i+1] = 8'h00;
    end
    do_reset();
    for (int i = 1; i <= 4; i++) exp_exec('hF0, 2*i, i, 3);
    arst = 0;
    run_to_end("overflow", 0, 1, 'h0A, 4);

    // Reset in the middle of a memory wait, then restart from address 0
    clear_imem();
    imem[0] = 8'h01; imem[1] = 8'h10; imem[2] = 8'hFF;
    ack_delay = 50;
    do_reset();
    arst = 0;
    for (int i = 0; i < 20 && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    check("mid_mem:req_seen", 32'(mem_req), 1);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_mem:waiting", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h10}));
    arst = 1;
    @(posedge clk); #1;
    check("mid_mem:req_drop", 32'(mem_req), 0);
    check_reset("rst_mid");
    sb.delete();
    ack_delay = 0;
    exp_mem('h10, 0, 0, 0);
    exp_exec('h01, 'h02, 0, 4, 1, 'h2C);
    arst = 0;
    @(negedge clk);
    check("mid_mem:fetch_addr", 32'(inst_addr), 0);
    run_to_end("after_rst", 1, 0, 'h04, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
